// File: rtl/par_serial_tx_pkg.sv
// Shared PHY definitions for the serial transmit/receive pair: alignment symbols,
// the number of comma symbols sent before data, and the link state encoding.
package par_serial_tx_pkg;

    localparam logic [7:0] PHY_COM_SYM    = 8'hBC;
    localparam logic [7:0] PHY_IDL_SYM    = 8'h7C;
    localparam int         PHY_SYNC_COUNT = 4;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } phy_state_e;

    // Symbol to place on the line at a symbol boundary.
    function automatic logic [7:0] select_symbol(
        input phy_state_e st,
        input logic       valid,
        input logic [7:0] data,
        input logic [7:0] com_sym,
        input logic [7:0] idl_sym
    );
        if (st == ST_SYNC) begin
            return com_sym;
        end
        return valid ? data : idl_sym;
    endfunction

endpackage

// File: rtl/par_serial_tx_piso_shift8.sv
// 8-bit parallel-in serial-out register: a load presents bit 7 immediately on
// the registered output and queues bits 6..0 to follow, one per clock.
module piso_shift8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       bit_out
);

    logic       bit_q;
    logic       bit_d;
    logic [6:0] shift_q;
    logic [6:0] shift_d;

    always_comb begin
        if (load) begin
            bit_d   = load_data[7];
            shift_d = load_data[6:0];
        end else begin
            bit_d   = shift_q[6];
            shift_d = {shift_q[5:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q   <= 1'b0;
            shift_q <= '0;
        end else begin
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign bit_out = bit_q;

endmodule

// File: rtl/par_serial_tx.sv
// Byte-to-serial transmitter: sends SYNC_COUNT comma symbols after reset, then
// streams offered bytes MSB first, filling empty symbol slots with idle.
module par_serial_tx
    import par_serial_tx_pkg::*;
#(
    parameter logic [7:0] COM_SYM    = PHY_COM_SYM,
    parameter logic [7:0] IDL_SYM    = PHY_IDL_SYM,
    parameter int         SYNC_COUNT = PHY_SYNC_COUNT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_ack,
    output logic       data_out,
    output logic       sync_done
);

    localparam int SCW = $clog2(SYNC_COUNT + 1);

    logic [2:0]     bit_cnt_q;
    logic [2:0]     bit_cnt_d;
    logic [SCW-1:0] sync_cnt_q;
    logic [SCW-1:0] sync_cnt_d;
    phy_state_e     state_q;
    phy_state_e     state_d;
    logic           sync_done_q;
    logic           sync_done_d;
    logic           load;
    logic [7:0]     sel;

    always_comb begin
        load        = (bit_cnt_q == 3'd0);
        bit_cnt_d   = bit_cnt_q + 3'd1;
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        sel         = select_symbol(state_q, valid_in, data_in, COM_SYM, IDL_SYM);
        // The boundary that loads the last comma is also the one that enters RUN.
        if (load && (state_q == ST_SYNC)) begin
            if (sync_cnt_q == SCW'(SYNC_COUNT - 1)) begin
                state_d    = ST_RUN;
                sync_cnt_d = '0;
            end else begin
                sync_cnt_d = sync_cnt_q + 1'b1;
            end
        end
        sync_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q   <= 3'd0;
            sync_cnt_q  <= '0;
            state_q     <= ST_SYNC;
            sync_done_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            state_q     <= state_d;
            sync_done_q <= sync_done_d;
        end
    end

    assign data_ack  = load & (state_q == ST_RUN) & valid_in;
    assign sync_done = sync_done_q;

    piso_shift8 u_piso (
        .clk       (clk),
        .rst_n     (reset),
        .load      (load),
        .load_data (sel),
        .bit_out   (data_out)
    );

endmodule

// File: tb/tb_par_serial_tx.sv
// Scoreboard bench for par_serial_tx: the driver queues the symbol expected in
// each slot, the monitor reassembles the serial stream and compares per symbol.
module tb_par_serial_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       data_ack;
    logic       data_out;
    logic       sync_done;

    typedef struct {
        logic [7:0] sym;
        bit         is_data;
    } exp_t;

    exp_t       sym_q[$];
    logic [7:0] ack_q[$];
    int         errors = 0;
    int         checks = 0;
    int         slot = 0;
    bit         armed = 1'b0;
    int         nbit = 0;
    logic [7:0] shreg = 8'h00;

    par_serial_tx dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_ack  (data_ack),
        .data_out  (data_out),
        .sync_done (sync_done)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: bits after the first post-reset edge are grouped into symbols.
    always @(posedge clk) armed <= reset;

    always @(negedge clk) begin
        exp_t e;
        if (!reset || !armed) begin
            nbit  = 0;
            shreg = 8'h00;
        end else begin
            shreg = {shreg[6:0], data_out};
            nbit++;
            if (nbit == 8) begin
                nbit = 0;
                if (sym_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL symbol: got %h expected none queued", shreg);
                end else begin
                    e = sym_q.pop_front();
                    check_byte("symbol", shreg, e.sym);
                    if (e.is_data) begin
                        if (ack_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL acked byte: got %h expected none acked", shreg);
                        end else begin
                            check_byte("acked byte", shreg, ack_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Called in the load cycle (bit_cnt==0); returns in the next load cycle.
    task automatic send_slot(input logic v, input logic [7:0] d,
                             input bit late = 1'b0, input logic [7:0] late_d = 8'h00);
        exp_t e;
        valid_in  = v;
        data_in   = d;
        e.is_data = (slot >= 4) && v;
        e.sym     = (slot < 4) ? 8'hBC : (v ? d : 8'h7C);
        sym_q.push_back(e);
        #1;
        check_bit($sformatf("ack slot %0d", slot), data_ack, e.is_data);
        check_bit($sformatf("sync_done slot %0d", slot), sync_done, slot >= 4);
        if (data_ack) ack_q.push_back(data_in);
        repeat (3) @(posedge clk);
        #1;
        if (late) begin
            valid_in = 1'b1;
            data_in  = late_d;
        end
        #1;
        check_bit($sformatf("ack mid slot %0d", slot), data_ack, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        slot++;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        slot  = 0;
    endtask

    task automatic reset_mid_symbol();
        exp_t e;
        valid_in  = 1'b1;
        data_in   = 8'hC3;
        e.is_data = 1'b1;
        e.sym     = 8'hC3;
        sym_q.push_back(e);
        #1;
        check_bit("ack before mid reset", data_ack, 1'b1);
        if (data_ack) ack_q.push_back(data_in);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_bit("data_out at mid reset", data_out, 1'b0);
        check_bit("sync_done at mid reset", sync_done, 1'b0);
        check_bit("ack at mid reset", data_ack, 1'b0);
        sym_q.delete();
        ack_q.delete();
        release_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        valid_in = 1'b1;
        data_in  = 8'hA5;
        #2 reset = 1'b0;
        #1;
        check_bit("reset data_out", data_out, 1'b0);
        check_bit("reset sync_done", sync_done, 1'b0);
        check_bit("reset data_ack", data_ack, 1'b0);
        release_reset();

        repeat (5) send_slot(1'b1, 8'hA5);
        repeat (3) send_slot(1'b0, 8'h00);
        send_slot(1'b1, 8'h00);
        send_slot(1'b1, 8'hFF);
        send_slot(1'b1, 8'h3C);
        send_slot(1'b0, 8'h00, 1'b1, 8'h55);
        send_slot(1'b1, 8'h55);

        reset_mid_symbol();
        repeat (5) send_slot(1'b1, 8'h81);
        send_slot(1'b0, 8'h00);

        repeat (2) @(negedge clk);
        #1;
        check_byte("symbols left", 8'(sym_q.size()), 8'd0);
        check_byte("acks left", 8'(ack_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
